// File: rtl/nco_search_ctrl.sv
// nco_search_ctrl
// Acquisition sequencer for the PSK correlator's NCO. A search walks the NCO
// frequency control word across a grid of n_bins bins spaced f_step apart.
// At each bin it restarts the correlator, waits SETTLE cycles for the NCO
// pipeline, and sums `dwell` energy reports. The bin with the largest sum
// (earliest bin on ties) is kept, and the NCO is parked there. lock is
// flagged when that sum reaches the threshold.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        start a search when idle / cancel a running search
//   f_start, f_step     first bin word and bin spacing (sampled on start)
//   n_bins, dwell       bin count and reports per bin, 0 means 1 (sampled on start)
//   threshold           lock threshold (sampled on start)
//   energy, energy_valid correlator energy report stream
//   control_word        NCO frequency word
//   phase_control_word  NCO phase word, always 0
//   corr_clear          one-cycle correlator restart pulse
//   busy, done, locked  status; done pulses once at the end of a search
//   best_word, best_energy  winning bin and its integrated energy
module nco_search_ctrl #(
  parameter int unsigned W      = 12,
  parameter int unsigned EW     = 20,
  parameter int unsigned SW     = 24,
  parameter int unsigned SETTLE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  f_start,
  input  logic [W-1:0]  f_step,
  input  logic [7:0]    n_bins,
  input  logic [7:0]    dwell,
  input  logic [SW-1:0] threshold,
  input  logic [EW-1:0] energy,
  input  logic          energy_valid,
  output logic [W-1:0]  control_word,
  output logic [W-1:0]  phase_control_word,
  output logic          corr_clear,
  output logic          busy,
  output logic          done,
  output logic          locked,
  output logic [W-1:0]  best_word,
  output logic [SW-1:0] best_energy
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TUNE,
    ST_SETTLE,
    ST_DWELL,
    ST_EVAL,
    ST_PARK
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [W-1:0]  step_q;
  logic [W-1:0]  cur_word;
  logic [7:0]    last_bin;
  logic [7:0]    dwell_q;
  logic [7:0]    bin_cnt;
  logic [7:0]    rep_cnt;
  logic [SW-1:0] thr_q;
  logic [SW-1:0] acc;
  logic [SW:0]   acc_sum;

  // One extra bit catches the carry that signals saturation.
  assign acc_sum = {1'b0, acc} + {{(SW + 1 - EW){1'b0}}, energy};

  assign busy               = (state != ST_IDLE);
  assign phase_control_word = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      step_q       <= '0;
      cur_word     <= '0;
      last_bin     <= '0;
      dwell_q      <= '0;
      bin_cnt      <= '0;
      rep_cnt      <= '0;
      thr_q        <= '0;
      acc          <= '0;
      control_word <= '0;
      corr_clear   <= 1'b0;
      done         <= 1'b0;
      locked       <= 1'b0;
      best_word    <= '0;
      best_energy  <= '0;
    end else begin
      corr_clear <= 1'b0;
      done       <= 1'b0;
      // abort overrides every state action, including EVAL/PARK updates
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              step_q      <= f_step;
              cur_word    <= f_start;
              last_bin    <= (n_bins == 8'd0) ? 8'd0 : n_bins - 8'd1;
              dwell_q     <= (dwell == 8'd0) ? 8'd1 : dwell;
              thr_q       <= threshold;
              bin_cnt     <= '0;
              best_energy <= '0;
              best_word   <= f_start;
              locked      <= 1'b0;
              state       <= ST_TUNE;
            end
          end
          ST_TUNE: begin
            control_word <= cur_word;
            corr_clear   <= 1'b1;
            settle_cnt   <= '0;
            state        <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt == CW'(SETTLE - 1)) begin
              acc     <= '0;
              rep_cnt <= '0;
              state   <= ST_DWELL;
            end else begin
              settle_cnt <= settle_cnt + CW'(1);
            end
          end
          ST_DWELL: begin
            if (energy_valid) begin
              acc     <= acc_sum[SW] ? '1 : acc_sum[SW-1:0];
              rep_cnt <= rep_cnt + 8'd1;
              if (rep_cnt + 8'd1 == dwell_q) state <= ST_EVAL;
            end
          end
          ST_EVAL: begin
            // strict compare keeps the earliest bin on equal energy
            if (acc > best_energy) begin
              best_energy <= acc;
              best_word   <= cur_word;
            end
            if (bin_cnt == last_bin) begin
              state <= ST_PARK;
            end else begin
              cur_word <= cur_word + step_q;
              bin_cnt  <= bin_cnt + 8'd1;
              state    <= ST_TUNE;
            end
          end
          ST_PARK: begin
            control_word <= best_word;
            corr_clear   <= 1'b1;
            locked       <= (best_energy >= thr_q);
            done         <= 1'b1;
            state        <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_search_ctrl.sv
module tb_nco_search_ctrl;

  localparam int unsigned W      = 12;
  localparam int unsigned EW     = 20;
  localparam int unsigned SW     = 24;
  localparam int unsigned SETTLE = 4;
  localparam longint unsigned SATMAX = (64'd1 << SW) - 64'd1;
  localparam longint unsigned EMAX   = (64'd1 << EW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  f_start;
  logic [W-1:0]  f_step;
  logic [7:0]    n_bins;
  logic [7:0]    dwell;
  logic [SW-1:0] threshold;
  logic [EW-1:0] energy;
  logic          energy_valid;
  logic [W-1:0]  control_word;
  logic [W-1:0]  phase_control_word;
  logic          corr_clear;
  logic          busy;
  logic          done;
  logic          locked;
  logic [W-1:0]  best_word;
  logic [SW-1:0] best_energy;

  nco_search_ctrl #(.W(W), .EW(EW), .SW(SW), .SETTLE(SETTLE)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .f_start            (f_start),
    .f_step             (f_step),
    .n_bins             (n_bins),
    .dwell              (dwell),
    .threshold          (threshold),
    .energy             (energy),
    .energy_valid       (energy_valid),
    .control_word       (control_word),
    .phase_control_word (phase_control_word),
    .corr_clear         (corr_clear),
    .busy               (busy),
    .done               (done),
    .locked             (locked),
    .best_word          (best_word),
    .best_energy        (best_energy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // per-bin energy table (used when a run asks for fixed energies)
  longint unsigned etab[256];
  // integrated energy of each completed bin, in bin order
  longint unsigned bin_acc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bin_word(input logic [W-1:0] fs, input logic [W-1:0] fst,
                                            input int unsigned i);
    logic [31:0] t;
    t = 32'(fs) + 32'(fst) * i;
    return t[W-1:0];
  endfunction

  // Drive random values on all configuration inputs while the block is busy.
  task automatic scramble();
    logic [31:0] r;
    r = $urandom; f_start = r[W-1:0];
    r = $urandom; f_step  = r[W-1:0];
    r = $urandom; n_bins  = r[7:0]; dwell = r[15:8];
    r = $urandom; threshold = r[SW-1:0];
    start = ($urandom_range(0, 7) == 0);
  endtask

  task automatic run_search(input logic [W-1:0] fs, input logic [W-1:0] fst,
                            input logic [7:0] nb, input logic [7:0] dw,
                            input logic [SW-1:0] thr, input bit use_tab,
                            input int abort_bin);
    int unsigned nbe, dwe, clears, settle_left, rep, best_i;
    longint unsigned acc_m, best_e;
    bit in_dwell, fin, abort_pending, seen;
    logic [31:0] r;
    logic [EW-1:0] e;
    nbe = (nb == 0) ? 1 : int'(nb);
    dwe = (dw == 0) ? 1 : int'(dw);
    clears = 0; settle_left = 0; rep = 0; acc_m = 0;
    in_dwell = 0; fin = 0; abort_pending = 0;
    bin_acc.delete();

    f_start = fs; f_step = fst; n_bins = nb; dwell = dw; threshold = thr;
    start = 1'b1; abort = 1'b0; energy_valid = 1'b0; energy = '0;
    tick();
    start = 1'b0;

    for (int cyc = 0; cyc < 40000 && !fin; cyc++) begin
      // reference best bin: highest sum, earliest bin on ties, starting from 0
      best_e = 0; best_i = 0;
      foreach (bin_acc[k]) if (bin_acc[k] > best_e) begin best_e = bin_acc[k]; best_i = k; end

      if (corr_clear) begin
        if (clears < nbe) check("bin_word", 64'(control_word), 64'(bin_word(fs, fst, clears)));
        else check("park_word", 64'(control_word), 64'(bin_word(fs, fst, best_i)));
        clears++;
        settle_left = SETTLE; in_dwell = 0; rep = 0; acc_m = 0;
      end

      if (done) begin
        check("done_with_park_clear", 64'(corr_clear), 64'd1);
        check("clear_count", 64'(clears), 64'(nbe + 1));
        check("bins_done", 64'(bin_acc.size()), 64'(nbe));
        check("best_word", 64'(best_word), 64'(bin_word(fs, fst, best_i)));
        check("best_energy", 64'(best_energy), best_e);
        check("locked", 64'(locked), 64'(best_e >= 64'(thr)));
        check("busy_after_done", 64'(busy), 64'd0);
        start = 1'b0; energy_valid = 1'b0;
        tick();
        check("done_single_pulse", 64'(done), 64'd0);
        fin = 1;
      end else if (abort_pending) begin
        start = 1'b0; energy_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hold_word", 64'(control_word), 64'(bin_word(fs, fst, abort_bin)));
        seen = 0;
        for (int k = 0; k < 8; k++) begin seen |= done | corr_clear; tick(); end
        check("abort_no_done", 64'(seen), 64'd0);
        fin = 1;
      end else begin
        scramble();
        if (settle_left > 0) begin
          // junk reports while the NCO settles must be ignored
          energy_valid = 1'b1; energy = '1;
          settle_left--;
          if (settle_left == 0) in_dwell = 1;
        end else if (in_dwell && rep < dwe) begin
          if ($urandom_range(0, 2) != 0) begin
            r = $urandom;
            e = use_tab ? etab[bin_acc.size()][EW-1:0] : r[EW-1:0];
            energy_valid = 1'b1; energy = e;
            acc_m += 64'(e);
            if (acc_m > SATMAX) acc_m = SATMAX;
            rep++;
            if (rep == dwe) begin bin_acc.push_back(acc_m); in_dwell = 0; end
            else if (abort_bin >= 0 && bin_acc.size() == abort_bin && rep == 1) abort_pending = 1;
          end else begin
            r = $urandom;
            energy_valid = 1'b0; energy = r[EW-1:0];
          end
        end else begin
          energy_valid = 1'b1; energy = '1;
        end
        tick();
      end
    end
    if (!fin) check("timeout", 64'd0, 64'd1);
    start = 1'b0; abort = 1'b0; energy_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] r1, r2, r3;
    int unsigned dwe_r;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; energy_valid = 1'b0; energy = '0;
    f_start = '0; f_step = '0; n_bins = '0; dwell = '0; threshold = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_word", 64'(control_word), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_best_energy", 64'(best_energy), 64'd0);

    // basic sweep with fixed per-bin energies
    etab[0] = 10; etab[1] = 50; etab[2] = 30; etab[3] = 5;
    run_search(12'h100, 12'h020, 8'd4, 8'd2, 24'd90, 1'b1, -1);
    check("phase_word", 64'(phase_control_word), 64'd0);

    // word wrap and ties
    etab[0] = 7; etab[1] = 7; etab[2] = 7;
    run_search(12'hFF0, 12'h020, 8'd3, 8'd2, 24'd100, 1'b1, -1);

    // saturation with threshold at full scale, then threshold above every bin
    etab[0] = EMAX; etab[1] = EMAX;
    run_search(12'h055, 12'h101, 8'd2, 8'd255, 24'hFFFFFF, 1'b1, -1);
    run_search(12'h055, 12'h101, 8'd2, 8'd3, 24'hFFFFFF, 1'b1, -1);

    // randomized configurations
    for (int t = 0; t < 6; t++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      dwe_r = (r2[2:0] == 0) ? 1 : int'(r2[2:0]);
      run_search(r1[W-1:0], r1[W+11:12], 8'(r2[10:8] % 6), 8'(r2[2:0] % 6),
                 SW'(r3 % (dwe_r * 32'h00100000)), 1'b0, -1);
    end

    // abort during bin 2, then minimal single-bin search
    run_search(12'h200, 12'h010, 8'd4, 8'd3, 24'd50, 1'b0, 2);
    run_search(12'h3AB, 12'h011, 8'd0, 8'd0, 24'd5, 1'b0, -1);

    // asynchronous reset in the middle of a dwell window
    f_start = 12'h321; f_step = 12'h001; n_bins = 8'd3; dwell = 8'd10; threshold = '0;
    start = 1'b1; energy_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < SETTLE + 3; k++) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_word", 64'(control_word), 64'd0);
    check("async_rst_best_word", 64'(best_word), 64'd0);
    check("async_rst_clear", 64'(corr_clear), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
